mdl_reg_ctrl: RTL and testbench
===============================

// Module: mdl_reg_ctrl
// PURPOSE
//  CPU write-port controller and LFO configuration register bank for IKA2151 (OPM).
//  - Accepts 8-bit bus writes: A0=0 is an address write, A0=1 is a data write.
//  - Commits data writes in the phi1 domain and raises the busy flag while doing so.
//  - Drives the LFO configuration inputs (LFRQ, AMD, PMD, W, TEST) and the LFRQ update strobe.
//  - Sits between the host bus pins and mdl_lfo; replaces today's constant tie-offs in the top level.
// PARAMETERS
//  BUSY_CYCLES  32  phi1 cycles o_BUSY stays high after a data write is committed (1..255)
// PORTS
//  i_EMUCLK          in   1  emulator master clock; the only clock
//  i_MRST            in   1  synchronous active-high reset
//  i_phi1_NCEN_n     in   1  phi1 negative-edge clock enable, active low; all commits happen here
//  i_CS_n            in   1  chip select, async to i_EMUCLK
//  i_WR_n            in   1  write strobe, async to i_EMUCLK
//  i_A0              in   1  0 = address, 1 = data
//  i_D               in   8  write data
//  o_DOUT            out  8  status read value = {o_BUSY, 7'h00}
//  o_BUSY            out  1  write busy flag
//  o_LFRQ            out  8  register 0x18
//  o_AMD             out  7  register 0x19 with D7=0
//  o_PMD             out  7  register 0x19 with D7=1
//  o_W               out  2  register 0x1B bits [1:0]
//  o_TEST            out  8  register 0x01
//  o_LFRQ_UPDATE_n   out  1  active-low strobe, one phi1 cycle long, after each 0x18 commit
// BEHAVIOUR
//  - Reset (i_MRST=1 at an i_EMUCLK edge):
//    - All registers, o_BUSY and the address latch go to 0; o_LFRQ_UPDATE_n=1; FSM goes to IDLE.
//    - Any pending write is discarded; reset wins over every simultaneous event.
//  - Bus synchronisation:
//    - CS_n, WR_n, A0 and D pass through a 2-FF synchroniser on i_EMUCLK.
//    - A write event is a synchronised WR_n rising edge while synchronised CS_n=0.
//    - A0 and D are sampled on the same edge; one event per strobe.
//  - Address write: always accepted, including during BUSY; takes effect at the next i_EMUCLK edge.
//  - FSM states and transitions:
//    - IDLE: on a data write, latch {addr,D}, go to PEND, set o_BUSY=1 on the same edge.
//    - PEND: at the next i_phi1_NCEN_n=0, write the target register; load counter=BUSY_CYCLES-1; go to BUSY.
//    - BUSY: decrement on each i_phi1_NCEN_n=0; at count 0 with enable, clear o_BUSY and go to IDLE.
//  - Data write while in PEND or BUSY: dropped, with no register change and no busy extension.
//  - Register map for committed writes:
//    - 0x01 -> o_TEST
//    - 0x18 -> o_LFRQ
//    - 0x19 -> D7 ? o_PMD : o_AMD, loaded from D[6:0]
//    - 0x1B -> o_W from D[1:0]
//    - Other addresses: no register change, but the busy sequence still runs.
//  - LFRQ update strobe:
//    - A commit to 0x18 drives o_LFRQ_UPDATE_n=0 from that phi1 enable until the next one.
//    - o_LFRQ has the new value while the strobe is low.
//  - Latency: write event -> register valid is 1..(phi1 period) i_EMUCLK cycles.
//  - Busy duration: o_BUSY is high for exactly BUSY_CYCLES phi1 enables after the commit.
//  - o_DOUT is combinational from o_BUSY; there is no read handshake.
// STRUCTURE
//  - Shared package ika2151_pkg:
//    - register address constants ADDR_TEST=8'h01, ADDR_LFRQ=8'h18, ADDR_PMDAMD=8'h19, ADDR_CTW=8'h1B
//    - FSM state enum {IDLE, PEND, BUSY}
//  - One sub-module, mdl_bus_sync: 2-FF synchroniser plus write-event edge detector, sized for 11 bits.
//  - Top level: instantiate between the pins and mdl_lfo; mdl_timinggen supplies i_MRST=~o_MRST_n and phi1 NCEN.
// TESTING
//  1. Reset: pulse i_MRST mid-BUSY -> all outputs 0, o_LFRQ_UPDATE_n=1, o_BUSY=0 on the next edge; a later write behaves normally.
//  2. LFRQ write: addr 0x18 then data 0xF2 -> o_LFRQ=0xF2 at the next phi1 NCEN; o_LFRQ_UPDATE_n low for exactly one phi1 cycle; o_BUSY high for 32 phi1 enables.
//  3. AMD/PMD split: data 0x60 then 0x87 to 0x19 (second after busy clears) -> o_AMD=0x60, o_PMD=0x07.
//  4. Write during busy: 0x1B<-0x02, then 0x1B<-0x03 while BUSY -> o_W=2; busy ends 32 enables after the first commit.
//  5. Unmapped and edge cases: data write to 0x20 -> no register change, busy still runs; BUSY_CYCLES=1 -> busy lasts exactly 1 enable.
//  6. Bus glitch: WR_n toggled with CS_n=1 -> no event; address write during BUSY retargets the next data write.

Source files
------------

// File: rtl/ika2151_pkg.sv
// ika2151_pkg: register addresses and write-port FSM states shared by the IKA2151 blocks.
package ika2151_pkg;
    localparam logic [7:0] ADDR_TEST   = 8'h01;
    localparam logic [7:0] ADDR_LFRQ   = 8'h18;
    localparam logic [7:0] ADDR_PMDAMD = 8'h19;
    localparam logic [7:0] ADDR_CTW    = 8'h1B;
    typedef enum logic [1:0] {IDLE, PEND, BUSY} wr_state_e;
endpackage

// File: rtl/mdl_reg_ctrl_if.sv
// mdl_reg_ctrl_if: host bus pins of the OPM write port (strobes, data, status).
interface mdl_reg_ctrl_if;
    logic       i_CS_n;
    logic       i_WR_n;
    logic       i_A0;
    logic [7:0] i_D;
    logic [7:0] o_DOUT;
    logic       o_BUSY;
    modport master (output i_CS_n, i_WR_n, i_A0, i_D, input o_DOUT, o_BUSY);
    modport slave (input i_CS_n, i_WR_n, i_A0, i_D, output o_DOUT, o_BUSY);
endinterface

// File: rtl/mdl_bus_sync.sv
// mdl_bus_sync: 2-FF synchroniser for the 11 async bus bits plus WR_n rising-edge write detector.
module mdl_bus_sync (
    input  logic       clk,
    input  logic       rst,
    input  logic       cs_n_i,
    input  logic       wr_n_i,
    input  logic       a0_i,
    input  logic [7:0] d_i,
    output logic       we_o,
    output logic       a0_o,
    output logic [7:0] d_o
);
    localparam logic [10:0] IDLE_VAL = 11'h600;
    logic [10:0] s1_q, s2_q;
    logic        wr_prev_q;
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q      <= IDLE_VAL;
            s2_q      <= IDLE_VAL;
            wr_prev_q <= 1'b1;
        end else begin
            s1_q      <= {cs_n_i, wr_n_i, a0_i, d_i};
            s2_q      <= s1_q;
            wr_prev_q <= s2_q[9];
        end
    end
    // A0/D come from the same stage as the strobe edge, so they are sampled together.
    assign we_o = ~s2_q[10] & s2_q[9] & ~wr_prev_q;
    assign a0_o = s2_q[8];
    assign d_o  = s2_q[7:0];
endmodule

// File: rtl/mdl_reg_ctrl.sv
// mdl_reg_ctrl: OPM CPU write-port controller; commits data writes on phi1 and holds the LFO config registers.
module mdl_reg_ctrl
    import ika2151_pkg::*;
#(
    parameter int BUSY_CYCLES = 32
) (
    input  logic              i_EMUCLK,
    input  logic              i_MRST,
    input  logic              i_phi1_NCEN_n,
    mdl_reg_ctrl_if.slave     bus,
    output logic [7:0]        o_LFRQ,
    output logic [6:0]        o_AMD,
    output logic [6:0]        o_PMD,
    output logic [1:0]        o_W,
    output logic [7:0]        o_TEST,
    output logic              o_LFRQ_UPDATE_n
);
    localparam logic [7:0] CNT_INIT = 8'(BUSY_CYCLES - 1);
    logic       we, wa0;
    logic [7:0] wd;
    logic       phi1;
    wr_state_e  state_q;
    logic [7:0] addr_q, paddr_q, pdata_q, cnt_q;
    logic       busy_q, upd_n_q;
    logic [7:0] lfrq_q, test_q;
    logic [6:0] amd_q, pmd_q;
    logic [1:0] w_q;

    mdl_bus_sync u_sync (
        .clk    (i_EMUCLK),
        .rst    (i_MRST),
        .cs_n_i (bus.i_CS_n),
        .wr_n_i (bus.i_WR_n),
        .a0_i   (bus.i_A0),
        .d_i    (bus.i_D),
        .we_o   (we),
        .a0_o   (wa0),
        .d_o    (wd)
    );

    assign phi1 = ~i_phi1_NCEN_n;

    always_ff @(posedge i_EMUCLK) begin
        if (i_MRST) begin
            state_q <= IDLE;
            addr_q  <= 8'h00;
            paddr_q <= 8'h00;
            pdata_q <= 8'h00;
            cnt_q   <= 8'h00;
            busy_q  <= 1'b0;
            upd_n_q <= 1'b1;
            lfrq_q  <= 8'h00;
            test_q  <= 8'h00;
            amd_q   <= 7'h00;
            pmd_q   <= 7'h00;
            w_q     <= 2'b00;
        end else begin
            if (we && !wa0) addr_q <= wd;
            // Strobe spans exactly one phi1 period: set on the commit enable, released on the next.
            if (phi1) upd_n_q <= !(state_q == PEND && paddr_q == ADDR_LFRQ);
            case (state_q)
                IDLE: begin
                    if (we && wa0) begin
                        paddr_q <= addr_q;
                        pdata_q <= wd;
                        busy_q  <= 1'b1;
                        state_q <= PEND;
                    end
                end
                PEND: begin
                    if (phi1) begin
                        if (paddr_q == ADDR_TEST) test_q <= pdata_q;
                        if (paddr_q == ADDR_LFRQ) lfrq_q <= pdata_q;
                        if (paddr_q == ADDR_PMDAMD && pdata_q[7]) pmd_q <= pdata_q[6:0];
                        if (paddr_q == ADDR_PMDAMD && !pdata_q[7]) amd_q <= pdata_q[6:0];
                        if (paddr_q == ADDR_CTW) w_q <= pdata_q[1:0];
                        cnt_q   <= CNT_INIT;
                        state_q <= BUSY;
                    end
                end
                BUSY: begin
                    if (phi1) begin
                        cnt_q   <= (cnt_q == 8'd0) ? cnt_q : cnt_q - 8'd1;
                        busy_q  <= (cnt_q != 8'd0);
                        state_q <= (cnt_q == 8'd0) ? IDLE : BUSY;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.o_BUSY      = busy_q;
    assign bus.o_DOUT      = {busy_q, 7'h00};
    assign o_LFRQ          = lfrq_q;
    assign o_AMD           = amd_q;
    assign o_PMD           = pmd_q;
    assign o_W             = w_q;
    assign o_TEST          = test_q;
    assign o_LFRQ_UPDATE_n = upd_n_q;
endmodule

// File: tb/tb_mdl_reg_ctrl.sv
// tb_mdl_reg_ctrl: directed plus randomized bus writes checked against a register-map model of the write port.
module tb_mdl_reg_ctrl;
    import ika2151_pkg::*;
    localparam int BC = 32;
    logic clk = 1'b0, rst = 1'b1, ncen_n = 1'b1;
    always #5 clk = ~clk;

    mdl_reg_ctrl_if bus0();
    mdl_reg_ctrl_if bus1();
    logic [7:0] lfrq0, test0, lfrq1, test1;
    logic [6:0] amd0, pmd0, amd1, pmd1;
    logic [1:0] w0, w1;
    logic       upd0, upd1;

    mdl_reg_ctrl #(.BUSY_CYCLES(BC)) dut0 (
        .i_EMUCLK(clk), .i_MRST(rst), .i_phi1_NCEN_n(ncen_n), .bus(bus0),
        .o_LFRQ(lfrq0), .o_AMD(amd0), .o_PMD(pmd0), .o_W(w0), .o_TEST(test0),
        .o_LFRQ_UPDATE_n(upd0)
    );
    mdl_reg_ctrl #(.BUSY_CYCLES(1)) dut1 (
        .i_EMUCLK(clk), .i_MRST(rst), .i_phi1_NCEN_n(ncen_n), .bus(bus1),
        .o_LFRQ(lfrq1), .o_AMD(amd1), .o_PMD(pmd1), .o_W(w1), .o_TEST(test1),
        .o_LFRQ_UPDATE_n(upd1)
    );

    int n_cmp = 0, n_err = 0;
    int ph = 0, nb0 = 0, nb1 = 0, upd_en = 0, upd_cyc = 0;
    logic busy_b0 = 1'b0, busy_b1 = 1'b0;
    logic [7:0] lfrq_at_upd = 8'h00;
    logic [7:0] m_addr, m_test, m_lfrq;
    logic [6:0] m_amd, m_pmd;
    logic [1:0] m_w;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void m_reset();
        m_addr = 8'h00; m_test = 8'h00; m_lfrq = 8'h00; m_amd = 7'h00; m_pmd = 7'h00; m_w = 2'b00;
    endfunction

    function automatic void m_commit(input logic [7:0] a, input logic [7:0] d);
        if (a == ADDR_TEST) m_test = d;
        else if (a == ADDR_LFRQ) m_lfrq = d;
        else if (a == ADDR_PMDAMD && d[7]) m_pmd = d[6:0];
        else if (a == ADDR_PMDAMD) m_amd = d[6:0];
        else if (a == ADDR_CTW) m_w = d[1:0];
    endfunction

    // One EMUCLK cycle: phi1 enable once every 4 cycles, counters sampled 1ns after the edge.
    task automatic tick();
        @(negedge clk);
        ph = (ph + 1) % 4;
        ncen_n = (ph != 0);
        @(posedge clk);
        #1;
        if (!ncen_n) begin
            if (busy_b0) nb0++;
            if (busy_b1) nb1++;
            if (!upd0) upd_en++;
        end
        if (!upd0) begin
            upd_cyc++;
            lfrq_at_upd = lfrq0;
        end
        busy_b0 = bus0.o_BUSY;
        busy_b1 = bus1.o_BUSY;
    endtask

    task automatic set_bus(input bit sel, input logic cs, input logic wr, input logic a0, input logic [7:0] d);
        if (!sel) begin
            bus0.i_CS_n = cs; bus0.i_WR_n = wr; bus0.i_A0 = a0; bus0.i_D = d;
        end else begin
            bus1.i_CS_n = cs; bus1.i_WR_n = wr; bus1.i_A0 = a0; bus1.i_D = d;
        end
    endtask

    task automatic bus_wr(input bit sel, input logic a0, input logic [7:0] d);
        set_bus(sel, 1'b0, 1'b1, a0, d); repeat (3) tick();
        set_bus(sel, 1'b0, 1'b0, a0, d); repeat (3) tick();
        set_bus(sel, 1'b0, 1'b1, a0, d); repeat (3) tick();
        set_bus(sel, 1'b1, 1'b1, a0, d); tick();
    endtask

    task automatic wait_idle(input bit sel);
        int k = 0;
        while ((sel ? bus1.o_BUSY : bus0.o_BUSY) !== 1'b0 && k < 2000) begin
            tick();
            k++;
        end
        check("idle_timeout", 32'(k < 2000), 32'd1);
    endtask

    task automatic check_regs(input string tag);
        check({tag, ".lfrq"}, 32'(lfrq0), 32'(m_lfrq));
        check({tag, ".amd"}, 32'(amd0), 32'(m_amd));
        check({tag, ".pmd"}, 32'(pmd0), 32'(m_pmd));
        check({tag, ".w"}, 32'(w0), 32'(m_w));
        check({tag, ".test"}, 32'(test0), 32'(m_test));
    endtask

    // Full write: address, data, optional second write while busy, then busy-length and strobe checks.
    task automatic do_txn(input string tag, input logic [7:0] a, input logic [7:0] d,
                          input bit during, input logic [7:0] a2, input logic [7:0] d2);
        bit is_lfrq;
        bus_wr(0, 1'b0, a);
        m_addr = a;
        nb0 = 0; upd_en = 0; upd_cyc = 0;
        bus_wr(0, 1'b1, d);
        is_lfrq = (m_addr == ADDR_LFRQ);
        m_commit(m_addr, d);
        check({tag, ".busy_set"}, 32'(bus0.o_BUSY), 32'd1);
        check({tag, ".dout_busy"}, 32'(bus0.o_DOUT), 32'h80);
        if (during) begin
            bus_wr(0, 1'b0, a2);
            m_addr = a2;
            bus_wr(0, 1'b1, d2);
        end
        wait_idle(0);
        check({tag, ".busy_enables"}, 32'(nb0), 32'(BC + 1));
        check({tag, ".dout_idle"}, 32'(bus0.o_DOUT), 32'h00);
        check({tag, ".upd_enables"}, 32'(upd_en), is_lfrq ? 32'd1 : 32'd0);
        check({tag, ".upd_cycles"}, 32'(upd_cyc), is_lfrq ? 32'd4 : 32'd0);
        if (is_lfrq) check({tag, ".lfrq_at_upd"}, 32'(lfrq_at_upd), 32'(d));
        check_regs(tag);
    endtask

    initial begin
        logic [7:0] ra, rd, ra2, rd2;
        m_reset();
        set_bus(0, 1'b1, 1'b1, 1'b0, 8'h00);
        set_bus(1, 1'b1, 1'b1, 1'b0, 8'h00);
        repeat (3) tick();
        rst = 1'b0;
        tick();
        check_regs("reset");
        check("reset.busy", 32'(bus0.o_BUSY), 32'd0);
        check("reset.upd_n", 32'(upd0), 32'd1);
        check("reset.dout", 32'(bus0.o_DOUT), 32'h00);

        do_txn("lfrq", ADDR_LFRQ, 8'hF2, 1'b0, 8'h00, 8'h00);
        check("lfrq.value", 32'(lfrq0), 32'hF2);
        do_txn("amd", ADDR_PMDAMD, 8'h60, 1'b0, 8'h00, 8'h00);
        do_txn("pmd", ADDR_PMDAMD, 8'h87, 1'b0, 8'h00, 8'h00);
        check("split.amd", 32'(amd0), 32'h60);
        check("split.pmd", 32'(pmd0), 32'h07);
        do_txn("wbusy", ADDR_CTW, 8'h02, 1'b1, ADDR_CTW, 8'h03);
        check("wbusy.w", 32'(w0), 32'd2);
        do_txn("unmapped", 8'h20, 8'h55, 1'b0, 8'h00, 8'h00);

        // Address write during busy retargets the following data write.
        do_txn("retarget", ADDR_LFRQ, 8'h11, 1'b1, ADDR_CTW, 8'hEE);
        nb0 = 0;
        bus_wr(0, 1'b1, 8'h01);
        m_commit(m_addr, 8'h01);
        wait_idle(0);
        check("retarget.busy_enables", 32'(nb0), 32'(BC + 1));
        check_regs("retarget");
        check("retarget.w", 32'(w0), 32'd1);

        // WR_n activity with CS_n deasserted is not a write.
        for (int i = 0; i < 4; i++) begin
            set_bus(0, 1'b1, 1'b0, 1'b1, 8'hAA); repeat (3) tick();
            set_bus(0, 1'b1, 1'b1, 1'b1, 8'hAA); repeat (3) tick();
        end
        check("glitch.busy", 32'(bus0.o_BUSY), 32'd0);
        check_regs("glitch");

        bus_wr(1, 1'b0, ADDR_LFRQ);
        nb1 = 0;
        bus_wr(1, 1'b1, 8'h5A);
        wait_idle(1);
        check("bc1.busy_enables", 32'(nb1), 32'd2);
        check("bc1.lfrq", 32'(lfrq1), 32'h5A);
        check("bc1.test", 32'(test1), 32'h00);

        bus_wr(0, 1'b0, ADDR_LFRQ);
        bus_wr(0, 1'b1, 8'h33);
        repeat (30) tick();
        check("rstmid.busy_before", 32'(bus0.o_BUSY), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        m_reset();
        check_regs("rstmid");
        check("rstmid.busy", 32'(bus0.o_BUSY), 32'd0);
        check("rstmid.upd_n", 32'(upd0), 32'd1);
        check("rstmid.lfrq1", 32'(lfrq1), 32'h00);
        tick();

        for (int n = 0; n < 12; n++) begin
            case ($urandom_range(0, 4))
                0: ra = ADDR_TEST;
                1: ra = ADDR_LFRQ;
                2: ra = ADDR_PMDAMD;
                3: ra = ADDR_CTW;
                default: ra = 8'($urandom_range(32, 255));
            endcase
            rd = 8'($urandom);
            ra2 = ($urandom_range(0, 1) != 0) ? ADDR_LFRQ : ADDR_TEST;
            rd2 = 8'($urandom);
            do_txn("rand", ra, rd, $urandom_range(0, 3) == 0, ra2, rd2);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
